mips_mc_controller: RTL and testbench

- Moore-style FSM controller that sequences a shared-memory multicycle MIPS datapath.
- One ALU, a single unified memory port, and an instruction register are reused across cycles. The block issues per-cycle mux selects, write enables and ALU control.
- Instruction set: lw, sw, R-type (add, sub, and, or, slt), beq, bne, addi, slti, j.
- Sits beside the multicycle datapath and replaces the single-cycle combinational controller.

---
 rtl/mips_mc_controller_if.sv | 34 +++
 rtl/mips_mc_controller.sv | 189 ++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mips_mc_controller_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The controller is the master: it consumes instruction fields and the ALU
// zero flag, and drives every select, enable and ALU control line.
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, state, instr_done, illegal
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, state, instr_done, illegal
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Moore FSM sequencing a shared-memory multicycle MIPS datapath
// (lw, sw, add/sub/and/or/slt, beq, bne, addi, slti, j).
module mips_mc_controller (
  input  logic                   clk,
  input  logic                   reset,
  mips_mc_controller_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_next_state;
  state_t     w_dec_state;
  logic       w_r_ok;
  logic [2:0] w_r_alu;
  logic       w_pcen, w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg;
  logic       w_regwrite, w_alusrca, w_instr_done, w_illegal;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_alucontrol;

  // State register; reset is synchronous and overrides any mid-instruction state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // R-type funct decode: supported flag and the matching ALU operation.
  always_comb begin
    w_r_ok  = 1'b1;
    w_r_alu = ALU_ADD;
    case (bus.funct)
      6'b100000: w_r_alu = ALU_ADD;
      6'b100010: w_r_alu = ALU_SUB;
      6'b100100: w_r_alu = ALU_AND;
      6'b100101: w_r_alu = ALU_OR;
      6'b101010: w_r_alu = ALU_SLT;
      default:   w_r_ok  = 1'b0;
    endcase
  end

  // Next-state and per-state output decode; during reset outputs follow FETCH
  // with every write/enable/pulse masked so no partial write can happen.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    w_next_state = S_FETCH;
    w_pcen       = 1'b0;
    w_iord       = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_regdst     = 1'b0;
    w_memtoreg   = 1'b0;
    w_regwrite   = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = 2'b00;
    w_pcsrc      = 2'b00;
    w_alucontrol = ALU_ADD;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    w_dec_state  = reset ? S_FETCH : r_state;

    case (w_dec_state)
      S_FETCH: begin
        w_alusrcb    = 2'b01;
        w_irwrite    = 1'b1;
        w_pcen       = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target PC+4+(imm<<2) is computed here and captured in ALUOut.
        w_alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW:    w_next_state = S_MEMADR;
          OP_BEQ, OP_BNE:  w_next_state = S_BRANCH;
          OP_ADDI, OP_SLTI: w_next_state = S_IEXEC;
          OP_J:            w_next_state = S_JUMP;
          OP_R: begin
            if (w_r_ok) w_next_state = S_RTEXEC;
            else        w_illegal    = 1'b1;
          end
          default:         w_illegal    = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b10;
        w_next_state = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord       = 1'b1;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg   = 1'b1;
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWR: begin
        w_iord       = 1'b1;
        w_memwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_RTEXEC: begin
        w_alusrca    = 1'b1;
        w_alucontrol = w_r_alu;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst     = 1'b1;
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca    = 1'b1;
        w_alucontrol = ALU_SUB;
        w_pcsrc      = 2'b01;
        w_pcen       = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
        w_instr_done = 1'b1;
      end
      S_IEXEC: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b10;
        w_alucontrol = (bus.op == OP_SLTI) ? ALU_SLT : ALU_ADD;
        w_next_state = S_IWB;
      end
      S_IWB: begin
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc      = 2'b10;
        w_pcen       = 1'b1;
        w_instr_done = 1'b1;
      end
      default: w_next_state = S_FETCH;
    endcase

    if (reset) begin
      w_pcen    = 1'b0;
      w_irwrite = 1'b0;
    end
  end

  assign bus.pcen       = w_pcen;
  assign bus.iord       = w_iord;
  assign bus.memwrite   = w_memwrite;
  assign bus.irwrite    = w_irwrite;
  assign bus.regdst     = w_regdst;
  assign bus.memtoreg   = w_memtoreg;
  assign bus.regwrite   = w_regwrite;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.alucontrol = w_alucontrol;
  assign bus.state      = r_state;
  assign bus.instr_done = w_instr_done;
  assign bus.illegal    = w_illegal;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Cycle-by-cycle directed bench for the multicycle MIPS controller.
module tb_mips_mc_controller;

  logic clk;
  logic reset;
  mips_mc_controller_if bus ();

  mips_mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         SLTI = 6'b001010, JMP = 6'b000010, BAD = 6'b111110;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010, F_NONE = 6'b000000;

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,state,instr_done,illegal}
  function automatic logic [20:0] ex(input logic pcen, iord, mw, irw, rd, m2r, rw, asa,
                                     input logic [1:0] asb, pcs, input logic [2:0] alu,
                                     input logic [3:0] st, input logic done, ill);
    return {pcen, iord, mw, irw, rd, m2r, rw, asa, asb, pcs, alu, st, done, ill};
  endfunction

  task automatic add(input string name, input logic rst, input logic [5:0] op, funct,
                     input logic zero, input logic [20:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.op = op; v.funct = funct; v.zero = zero; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Hand-derived per-state expectations.
  logic [20:0] e_fetch, e_decode, e_memadr, e_memrd, e_memwb, e_memwr, e_aluwb, e_iwb;
  logic [20:0] e_jump, e_illegal;

  // Adds FETCH + DECODE rows for one instruction.
  task automatic fd(input string n, input logic [5:0] op, funct, input logic zero);
    add({n, "_fetch"},  1'b0, op, funct, zero, e_fetch);
    add({n, "_decode"}, 1'b0, op, funct, zero, e_decode);
  endtask

  task automatic rtype(input string n, input logic [5:0] funct, input logic [2:0] alu);
    fd(n, RT, funct, 1'b0);
    add({n, "_rtexec"}, 1'b0, RT, funct, 1'b0,
        ex(0,0,0,0,0,0,0,1,2'b00,2'b00,alu,4'd6,0,0));
    add({n, "_aluwb"},  1'b0, RT, funct, 1'b0, e_aluwb);
  endtask

  task automatic branch(input string n, input logic [5:0] op, input logic zero,
                        input logic taken);
    fd(n, op, F_NONE, zero);
    add({n, "_branch"}, 1'b0, op, F_NONE, zero,
        ex(taken,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,4'd8,1,0));
  endtask

  task automatic itype(input string n, input logic [5:0] op, input logic [2:0] alu);
    fd(n, op, F_NONE, 1'b0);
    add({n, "_iexec"}, 1'b0, op, F_NONE, 1'b0,
        ex(0,0,0,0,0,0,0,1,2'b10,2'b00,alu,4'd9,0,0));
    add({n, "_iwb"},   1'b0, op, F_NONE, 1'b0, e_iwb);
  endtask

  logic [20:0] act;

  initial begin
    e_fetch   = ex(1,0,0,1,0,0,0,0,2'b01,2'b00,3'b010,4'd0,0,0);
    e_decode  = ex(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,4'd1,0,0);
    e_illegal = ex(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,4'd1,0,1);
    e_memadr  = ex(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,4'd2,0,0);
    e_memrd   = ex(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,4'd3,0,0);
    e_memwb   = ex(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010,4'd4,1,0);
    e_memwr   = ex(0,1,1,0,0,0,0,0,2'b00,2'b00,3'b010,4'd5,1,0);
    e_aluwb   = ex(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,4'd7,1,0);
    e_iwb     = ex(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010,4'd10,1,0);
    e_jump    = ex(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,4'd11,1,0);

    // Reset state: FETCH selects, enables masked.
    add("reset_hold", 1'b1, LW, F_NONE, 1'b0, ex(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,4'd0,0,0));
    // lw: 5 cycles.
    fd("lw", LW, F_NONE, 1'b0);
    add("lw_memadr", 1'b0, LW, F_NONE, 1'b0, e_memadr);
    add("lw_memrd",  1'b0, LW, F_NONE, 1'b0, e_memrd);
    add("lw_memwb",  1'b0, LW, F_NONE, 1'b0, e_memwb);
    // R-type: 4 cycles each.
    rtype("sub", F_SUB, 3'b110);
    rtype("or",  F_OR,  3'b001);
    rtype("add", F_ADD, 3'b010);
    rtype("and", F_AND, 3'b000);
    rtype("slt", F_SLT, 3'b111);
    // Branches: 3 cycles each.
    branch("beq_z1", BEQ, 1'b1, 1'b1);
    branch("beq_z0", BEQ, 1'b0, 1'b0);
    branch("bne_z0", BNE, 1'b0, 1'b1);
    branch("bne_z1", BNE, 1'b1, 1'b0);
    // Immediates.
    itype("slti", SLTI, 3'b111);
    itype("addi", ADDI, 3'b010);
    // Illegal opcode and unsupported R funct: 2 cycles, no writes.
    add("badop_fetch",  1'b0, BAD, F_NONE, 1'b0, e_fetch);
    add("badop_decode", 1'b0, BAD, F_NONE, 1'b0, e_illegal);
    add("badfn_fetch",  1'b0, RT, F_NONE, 1'b0, e_fetch);
    add("badfn_decode", 1'b0, RT, F_NONE, 1'b0, e_illegal);
    // j: FETCH with garbage op must not matter.
    add("j_fetch",  1'b0, BAD, F_NONE, 1'b0, e_fetch);
    add("j_decode", 1'b0, JMP, F_NONE, 1'b0, e_decode);
    add("j_jump",   1'b0, JMP, F_NONE, 1'b0, e_jump);
    // sw interrupted by reset in MEMWR, held 2 cycles.
    fd("sw_a", SW, F_NONE, 1'b0);
    add("sw_a_memadr", 1'b0, SW, F_NONE, 1'b0, e_memadr);
    add("sw_rst1", 1'b1, SW, F_NONE, 1'b0, ex(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,4'd5,0,0));
    add("sw_rst2", 1'b1, SW, F_NONE, 1'b0, ex(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,4'd0,0,0));
    // Post-reset: full FETCH, then a complete sw (4 cycles).
    fd("sw_b", SW, F_NONE, 1'b0);
    add("sw_b_memadr", 1'b0, SW, F_NONE, 1'b0, e_memadr);
    add("sw_b_memwr",  1'b0, SW, F_NONE, 1'b0, e_memwr);
    add("final_fetch", 1'b0, LW, F_NONE, 1'b0, e_fetch);

    reset = 1'b1;
    bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst;
      bus.op    = vecs[i].op;
      bus.funct = vecs[i].funct;
      bus.zero  = vecs[i].zero;
      @(negedge clk);
      act = {bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
             bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol,
             bus.state, bus.instr_done, bus.illegal};
      check(vecs[i].name, act, vecs[i].exp);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
